kernel_pr_rank_accum: RTL and testbench

Consumer stage that drains the 32-bit, depth-2 contribution FIFO feeding the PageRank update path. It reads packets of one header word followed by N contribution words, sums the contributions, and applies damping: rank = BASE + (sum * DAMP) >> 16. It emits one {vertex id, new rank} record per packet into the downstream rank-writeback FIFO. Both sides use the ap_fifo handshake: empty_n/read upstream, full_n/write downstream.

---
 rtl/kernel_pr_pkg.sv | 25 ++
 rtl/kernel_pr_rank_accum_scale.sv | 53 +++++
 rtl/kernel_pr_rank_accum.sv | 116 +++++++++++
 tb/tb_kernel_pr_rank_accum.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/kernel_pr_pkg.sv
// rtl/kernel_pr_pkg.sv - shared types and constants for the PageRank rank accumulator
//
// Holds the accumulator FSM state enum, the header field offsets and the
// default damping/base constants (Q0.16 damping, Q16.16 base rank).
package kernel_pr_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int VID_W_DEFAULT  = 24;
    localparam int CNT_W_DEFAULT  = 8;

    // Header word layout: {vid[31:8], cnt[7:0]}
    localparam int VID_LSB = 8;
    localparam int CNT_LSB = 0;

    localparam logic [31:0] DAMP_DEFAULT = 32'd55705;  // 0.85 in Q0.16
    localparam logic [31:0] BASE_DEFAULT = 32'd9830;   // 0.15 in Q16.16

    typedef enum logic [1:0] {
        HDR   = 2'd0,
        ACC   = 2'd1,
        SCALE = 2'd2,
        EMIT  = 2'd3
    } state_t;

endpackage

// File: rtl/kernel_pr_rank_accum_scale.sv
// rtl/kernel_pr_rank_accum_scale.sv - registered damping multiply-add for the SCALE stage
//
// rank <= BASE + (sum * DAMP)[47:16], registered when load is high.
// With KERNEL_PR_ACCUM_SAT_EN defined the final add saturates to all ones;
// otherwise it wraps modulo 2^DATA_W.
//
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset (clears rank)
//   load   in   capture a new rank this cycle
//   sum    in   DATA_W accumulated contributions, Q16.16
//   rank   out  DATA_W registered damped rank, Q16.16
module kernel_pr_rank_accum_scale
    import kernel_pr_pkg::*;
#(
    parameter int              DATA_W = DATA_W_DEFAULT,
    parameter logic [31:0]     DAMP   = DAMP_DEFAULT,
    parameter logic [31:0]     BASE   = BASE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] sum,
    output logic [DATA_W-1:0] rank
);

    logic [2*DATA_W-1:0] prod;
    logic [DATA_W:0]     total;
    logic [DATA_W-1:0]   rank_next;

    // Q16.16 * Q0.16 gives Q16.32; bits [47:16] bring it back to Q16.16.
    assign prod  = {{DATA_W{1'b0}}, sum} * {{DATA_W{1'b0}}, DAMP[DATA_W-1:0]};
    assign total = {1'b0, prod[DATA_W+15:16]} + {1'b0, BASE[DATA_W-1:0]};

`ifdef KERNEL_PR_ACCUM_SAT_EN
    assign rank_next = total[DATA_W] ? {DATA_W{1'b1}} : total[DATA_W-1:0];
    logic unused_bits;
    assign unused_bits = &{1'b0, prod[2*DATA_W-1:DATA_W+16], prod[15:0]};
`else
    assign rank_next = total[DATA_W-1:0];
    logic unused_bits;
    assign unused_bits = &{1'b0, total[DATA_W], prod[2*DATA_W-1:DATA_W+16], prod[15:0]};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rank <= '0;
        end else if (load) begin
            rank <= rank_next;
        end
    end

endmodule

// File: rtl/kernel_pr_rank_accum.sv
// rtl/kernel_pr_rank_accum.sv - drains contribution packets and emits damped PageRank records
//
// Reads {vid, cnt} headers followed by cnt contribution words from an
// ap_fifo source, sums them, damps the sum and writes {vid, rank} to an
// ap_fifo sink. Optional macro KERNEL_PR_ACCUM_SAT_EN makes both the
// accumulation and the final base add saturate instead of wrapping.
//
// Ports:
//   clk         in   clock
//   reset       in   synchronous active-high reset
//   in_empty_n  in   upstream FIFO has data, in_dout valid
//   in_dout     in   upstream FIFO head word
//   in_read     out  pop upstream FIFO
//   out_full_n  in   downstream FIFO has space
//   out_write   out  push out_din
//   out_din     out  {vid, rank}
//   busy        out  high whenever not waiting for a header
module kernel_pr_rank_accum
    import kernel_pr_pkg::*;
#(
    parameter int          DATA_W = DATA_W_DEFAULT,
    parameter int          VID_W  = VID_W_DEFAULT,
    parameter int          CNT_W  = CNT_W_DEFAULT,
    parameter logic [31:0] DAMP   = DAMP_DEFAULT,
    parameter logic [31:0] BASE   = BASE_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_empty_n,
    input  logic [DATA_W-1:0]       in_dout,
    output logic                    in_read,
    input  logic                    out_full_n,
    output logic                    out_write,
    output logic [VID_W+DATA_W-1:0] out_din,
    output logic                    busy
);

    state_t            state;
    logic [VID_W-1:0]  vid;
    logic [CNT_W-1:0]  remain;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] sum_next;
    logic [DATA_W:0]   acc;
    logic [DATA_W-1:0] rank;
    logic [CNT_W-1:0]  hdr_cnt;

    // Handshakes follow the FIFO flags directly so a word can move every cycle.
    assign in_read   = !reset && in_empty_n && ((state == HDR) || (state == ACC));
    assign out_write = !reset && out_full_n && (state == EMIT);
    assign busy      = (state != HDR);
    assign out_din   = {vid, rank};

    assign hdr_cnt = in_dout[CNT_LSB +: CNT_W];
    assign acc     = {1'b0, sum} + {1'b0, in_dout};

`ifdef KERNEL_PR_ACCUM_SAT_EN
    assign sum_next = acc[DATA_W] ? {DATA_W{1'b1}} : acc[DATA_W-1:0];
`else
    assign sum_next = acc[DATA_W-1:0];
    logic unused_carry;
    assign unused_carry = acc[DATA_W];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= HDR;
            vid    <= '0;
            remain <= '0;
            sum    <= '0;
        end else begin
            case (state)
                HDR: begin
                    if (in_read) begin
                        vid    <= in_dout[VID_LSB +: VID_W];
                        remain <= hdr_cnt;
                        sum    <= '0;
                        state  <= (hdr_cnt != '0) ? ACC : SCALE;
                    end
                end
                ACC: begin
                    if (in_read) begin
                        sum    <= sum_next;
                        remain <= remain - 1'b1;
                        if (remain == CNT_W'(1)) begin
                            state <= SCALE;
                        end
                    end
                end
                SCALE: begin
                    state <= EMIT;
                end
                EMIT: begin
                    if (out_write) begin
                        state <= HDR;
                    end
                end
                default: begin
                    state <= HDR;
                end
            endcase
        end
    end

    kernel_pr_rank_accum_scale #(
        .DATA_W (DATA_W),
        .DAMP   (DAMP),
        .BASE   (BASE)
    ) u_scale (
        .clk   (clk),
        .reset (reset),
        .load  (state == SCALE),
        .sum   (sum),
        .rank  (rank)
    );

endmodule

// File: tb/tb_kernel_pr_rank_accum.sv
// tb/tb_kernel_pr_rank_accum.sv - self-checking bench for kernel_pr_rank_accum
module tb_kernel_pr_rank_accum;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_empty_n;
    logic [31:0] in_dout;
    logic        in_read;
    logic        out_full_n;
    logic        out_write;
    logic [55:0] out_din;
    logic        busy;

    kernel_pr_rank_accum dut (
        .clk        (clk),
        .reset      (reset),
        .in_empty_n (in_empty_n),
        .in_dout    (in_dout),
        .in_read    (in_read),
        .out_full_n (out_full_n),
        .out_write  (out_write),
        .out_din    (out_din),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] q[$];
    int          cyc;
    bit          toggle;
    int          bp_start;
    int          bp_len;

    typedef struct {
        string           name;
        logic [23:0]     vid;
        logic [7:0]      cnt;
        logic [3:0][31:0] pl;
        logic [31:0]     rank;
        int              wcyc;
        bit              tog;
        int              bps;
        int              bpl;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        in_empty_n = (q.size() > 0) && (!toggle || (cyc % 2 == 0));
        in_dout    = (q.size() > 0) ? q[0] : 32'h0;
        out_full_n = !(cyc >= bp_start && cyc < bp_start + bp_len);
    endtask

    task automatic run_packet(input vec_t v, input bit extra);
        int   pops;
        int   bad_read;
        int   unstable;
        int   wcyc;
        int   late_writes;
        logic [55:0] got;
        logic [55:0] exp_din;
        bit   popped;
        exp_din  = {v.vid, v.rank};
        toggle   = v.tog;
        bp_start = v.bps;
        bp_len   = v.bpl;
        q.delete();
        q.push_back({v.vid, v.cnt});
        for (int i = 0; i < int'(v.cnt); i++) q.push_back(v.pl[i]);
        if (extra) q.push_back(32'h0000DEAD);
        pops = 0; bad_read = 0; unstable = 0; wcyc = -1; late_writes = 0; got = '0;
        cyc = 0;
        drive();
        while (cyc < 300 && wcyc < 0) begin
            @(negedge clk);
            if (in_read && !in_empty_n) bad_read++;
            if (cyc >= bp_start && cyc < bp_start + bp_len) begin
                if (in_read || out_write) bad_read++;
                if (out_din !== exp_din) unstable++;
            end
            if (out_write) begin
                wcyc = cyc;
                got  = out_din;
            end
            popped = in_read;
            @(posedge clk); #1;
            if (popped) begin
                void'(q.pop_front());
                pops++;
            end
            cyc++;
            drive();
        end
        chk({v.name, " write_cycle"}, 64'(wcyc), 64'(v.wcyc));
        chk({v.name, " out_din"}, 64'(got), 64'(exp_din));
        chk({v.name, " pops"}, 64'(pops), 64'(int'(v.cnt) + 1));
        chk({v.name, " bad_read"}, 64'(bad_read), 64'd0);
        if (v.bpl > 0) chk({v.name, " din_stable"}, 64'(unstable), 64'd0);
        // No second record may follow while nothing else is queued.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (out_write) late_writes++;
            @(posedge clk); #1;
            cyc++;
        end
        chk({v.name, " single_write"}, 64'(late_writes), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q.delete();
        cyc = 0;
        drive();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    vec_t vecs[6];
    vec_t v7;

    initial begin
        toggle = 1'b0; bp_start = 0; bp_len = 0; cyc = 0;
        reset = 1'b1;
        q.delete();
        q.push_back(32'h00000500);
        drive();
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset in_read", 64'(in_read), 64'd0);
        chk("reset out_write", 64'(out_write), 64'd0);
        chk("reset out_din", 64'(out_din), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        q.delete();
        drive();
        @(negedge clk);
        chk("idle busy", 64'(busy), 64'd0);
        chk("idle in_read", 64'(in_read), 64'd0);
        @(posedge clk); #1;

        vecs[0] = '{"two_ones",   24'd5, 8'd2, {32'h0, 32'h0, 32'h00010000, 32'h00010000}, 32'h0001D998, 4, 1'b0, 0, 0};
        vecs[1] = '{"cnt_zero",   24'd9, 8'd0, {32'h0, 32'h0, 32'h0, 32'h0},               32'h00002666, 2, 1'b0, 0, 0};
`ifdef KERNEL_PR_ACCUM_SAT_EN
        vecs[2] = '{"overflow",   24'd3, 8'd2, {32'h0, 32'h0, 32'h00020000, 32'hFFFF0000}, 32'hD9992665, 4, 1'b0, 0, 0};
`else
        vecs[2] = '{"overflow",   24'd3, 8'd2, {32'h0, 32'h0, 32'h00020000, 32'hFFFF0000}, 32'h0000FFFF, 4, 1'b0, 0, 0};
`endif
        // sum 6 -> (6*55705)>>16 = 5, plus 9830 = 0x266B
        vecs[3] = '{"small_sum",  24'hABCDEF, 8'd3, {32'h0, 32'd3, 32'd2, 32'd1},          32'h0000266B, 5, 1'b0, 0, 0};
        vecs[4] = '{"toggle",     24'd5, 8'd2, {32'h0, 32'h0, 32'h00010000, 32'h00010000}, 32'h0001D998, 6, 1'b1, 0, 0};
        vecs[5] = '{"one_one",    24'd7, 8'd1, {32'h0, 32'h0, 32'h0, 32'h00010000},        32'h0000FFFF, 3, 1'b0, 0, 0};

        for (int i = 0; i < 6; i++) run_packet(vecs[i], 1'b0);

        // Backpressure: sink full for 10 cycles from EMIT entry (cycle 4); a
        // spare word sits upstream to expose any premature read.
        run_packet('{"backpressure", 24'd5, 8'd2, {32'h0, 32'h0, 32'h00010000, 32'h00010000},
                     32'h0001D998, 14, 1'b0, 4, 10}, 1'b1);
        bp_len = 0;
        do_reset();

        // Reset after the first of three payloads: nothing may be emitted.
        begin
            int   wr;
            bit   popped;
            toggle = 1'b0;
            q.delete();
            q.push_back({24'd1, 8'd3});
            q.push_back(32'h00010000);
            q.push_back(32'h00010000);
            q.push_back(32'h00010000);
            cyc = 0;
            wr = 0;
            drive();
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                if (out_write) wr++;
                popped = in_read;
                @(posedge clk); #1;
                if (popped) void'(q.pop_front());
                cyc++;
                drive();
            end
            reset = 1'b1;
            q.delete();
            drive();
            @(negedge clk);
            chk("midreset in_read", 64'(in_read), 64'd0);
            if (out_write) wr++;
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            chk("midreset busy", 64'(busy), 64'd0);
            for (int i = 0; i < 6; i++) begin
                if (out_write) wr++;
                @(negedge clk);
            end
            chk("midreset no_write", 64'(wr), 64'd0);
            @(posedge clk); #1;
        end

        v7 = '{"after_reset", 24'd7, 8'd1, {32'h0, 32'h0, 32'h0, 32'h00010000}, 32'h0000FFFF, 3, 1'b0, 0, 0};
        run_packet(v7, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
